// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide controller.
// Build option: define MDU_MADD_EN to enable madd/maddu/msub/msubu.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // Ops that open a busy window; anything else is mthi/mtlo or a no-op.
    function automatic logic is_md_class(input logic [3:0] op);
        case (md_op_e'(op))
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_md_calc.sv
// Combinational 64-bit result generator for the MD unit.
// Build option: MDU_MADD_EN adds the accumulate/subtract forms.
module md_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo,
    output logic [31:0] new_hi,
    output logic [31:0] new_lo,
    output logic        write_en
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic        div_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] result;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both forms: signed divide works on magnitudes
    // and fixes signs afterwards, which also yields 0x80000000 / -1 = 0x80000000.
    assign div_signed = (md_op_e'(op) == MD_DIV);
    assign a_mag      = a[31] ? -a : a;
    assign b_mag      = b[31] ? -b : b;
    assign num        = div_signed ? a_mag : a;
    assign den        = (b == 32'd0) ? 32'd1 : (div_signed ? b_mag : b);
    assign quo_mag    = num / den;
    assign rem_mag    = num % den;
    assign quo        = (div_signed && (a[31] ^ b[31])) ? -quo_mag : quo_mag;
    assign rem        = (div_signed && a[31]) ? -rem_mag : rem_mag;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        result   = 64'd0;
        write_en = 1'b0;
        case (md_op_e'(op))
            MD_MULT:  begin result = sprod;      write_en = 1'b1; end
            MD_MULTU: begin result = uprod;      write_en = 1'b1; end
            MD_DIV,
            MD_DIVU:  begin result = {rem, quo}; write_en = (b != 32'd0); end
`ifdef MDU_MADD_EN
            MD_MADD:  begin result = hilo + sprod; write_en = 1'b1; end
            MD_MADDU: begin result = hilo + uprod; write_en = 1'b1; end
            MD_MSUB:  begin result = hilo - sprod; write_en = 1'b1; end
            MD_MSUBU: begin result = hilo - uprod; write_en = 1'b1; end
`endif
            default:  begin result = 64'd0;      write_en = 1'b0; end
        endcase
    end

    assign new_hi = result[63:32];
    assign new_lo = result[31:0];

`ifndef MDU_MADD_EN
    logic unused_hilo;
    assign unused_hilo = ^hilo;
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller owning architectural HI/LO.
// Build option: MDU_MADD_EN enables madd-class ops (MULT_CYCLES latency).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_we;
    logic        start_md;

    md_calc u_md_calc (
        .op       (md_op),
        .a        (md_a),
        .b        (md_b),
        .hilo     ({hi_q, lo_q}),
        .new_hi   (calc_hi),
        .new_lo   (calc_lo),
        .write_en (calc_we)
    );

    assign start_md = md_start & is_md_class(md_op);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        case (state_q)
            ST_IDLE: begin
                if (start_md) begin
                    // Result is captured at start; the busy window only models latency.
                    pend_hi_d = calc_hi;
                    pend_lo_d = calc_lo;
                    pend_we_d = calc_we;
                    cnt_d     = is_div_class(md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    busy_d    = 1'b1;
                    state_d   = ST_BUSY;
                end else if (md_start && (md_op_e'(md_op) == MD_MTHI)) begin
                    hi_d = md_a;
                end else if (md_start && (md_op_e'(md_op) == MD_MTLO)) begin
                    lo_d = md_a;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    // NOTE: pending-result registers are reset too, so an aborted op leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    assign md_busy  = busy_q;
    assign md_stall = busy_q | start_md;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed spec cases plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_busy  (md_busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    function automatic bit model_is_md(input logic [3:0] op);
        if (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU) return 1'b1;
`ifdef MDU_MADD_EN
        if (op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // {write, new_hi, new_lo} from plain 64-bit integer arithmetic.
    function automatic logic [64:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
        longint          sa, sb;
        longint unsigned ua, ub, acc;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {h, l};
        case (op)
            OP_MULT:  return {1'b1, 64'(sa * sb)};
            OP_MULTU: return {1'b1, ua * ub};
            OP_DIV:   if (b == 32'd0) return {1'b0, h, l};
                      else return {1'b1, 32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  if (b == 32'd0) return {1'b0, h, l};
                      else return {1'b1, 32'(ua % ub), 32'(ua / ub)};
`ifdef MDU_MADD_EN
            OP_MADD:  return {1'b1, acc + 64'(sa * sb)};
            OP_MADDU: return {1'b1, acc + ua * ub};
            OP_MSUB:  return {1'b1, acc - 64'(sa * sb)};
            OP_MSUBU: return {1'b1, acc - ua * ub};
`endif
            default:  return {1'b0, h, l};
        endcase
    endfunction

    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [64:0] r;
        int          n;
        r = model_op(op, a, b, m_hi, m_lo);
        n = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
        @(negedge clk);
        md_start = 1'b1; md_op = op; md_a = a; md_b = b;
        #1;
        checks++;
        if (md_stall !== 1'b1) begin
            failures++;
            $display("FAIL %s start_stall got=%b exp=1", name, md_stall);
        end
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE;
        #1;
        for (int i = 1; i <= n; i++) begin
            checks++;
            if (md_busy !== 1'b1 || md_stall !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
                failures++;
                $display("FAIL %s busy_cycle%0d busy=%b stall=%b hi=%h lo=%h exp busy=1 stall=1 hi=%h lo=%h",
                         name, i, md_busy, md_stall, hi, lo, m_hi, m_lo);
            end
            @(negedge clk);
            #1;
        end
        if (r[64]) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        checks++;
        if (md_busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL %s commit busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                     name, md_busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic mt_write(input logic [3:0] op, input logic [31:0] a, input string name);
        @(negedge clk);
        md_start = 1'b1; md_op = op; md_a = a; md_b = $urandom;
        #1;
        checks++;
        if (md_stall !== 1'b0) begin
            failures++;
            $display("FAIL %s mt_stall got=%b exp=0", name, md_stall);
        end
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE;
        #1;
        if (op == OP_MTHI) m_hi = a; else m_lo = a;
        checks++;
        if (md_busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL %s mt_write busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                     name, md_busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; md_start = 1'b0; md_op = OP_NONE; md_a = '0; md_b = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b stall=%b hi=%h lo=%h exp 0/0/0/0", md_busy, md_stall, hi, lo);
        end
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_directed();
        run_md(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL mult_const hi=%h lo=%h exp hi=ffffffff lo=fffffff1", hi, lo);
        end
        run_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
        checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            failures++;
            $display("FAIL multu_const hi=%h lo=%h exp hi=00000001 lo=fffffffe", hi, lo);
        end
        run_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_by2");
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL div_const hi=%h lo=%h exp hi=ffffffff lo=fffffffd", hi, lo);
        end
        run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
            failures++;
            $display("FAIL div_ovf_const hi=%h lo=%h exp hi=00000000 lo=80000000", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        mt_write(OP_MTHI, 32'h11, "mthi_pre");
        mt_write(OP_MTLO, 32'h22, "mtlo_pre");
        run_md(OP_DIV, 32'd1234, 32'd0, "div_by_zero");
        run_md(OP_DIVU, 32'hFFFF_0000, 32'd0, "divu_by_zero");
        checks++;
        if (hi !== 32'h11 || lo !== 32'h22) begin
            failures++;
            $display("FAIL div0_keep hi=%h lo=%h exp hi=00000011 lo=00000022", hi, lo);
        end
    endtask

    task automatic test_nop();
        logic [3:0] codes[$];
        codes = '{OP_NONE, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`ifndef MDU_MADD_EN
        codes.push_back(OP_MADD); codes.push_back(OP_MADDU);
        codes.push_back(OP_MSUB); codes.push_back(OP_MSUBU);
`endif
        foreach (codes[k]) begin
            @(negedge clk);
            md_start = 1'b1; md_op = codes[k]; md_a = $urandom; md_b = $urandom;
            #1;
            checks++;
            if (md_stall !== 1'b0) begin
                failures++;
                $display("FAIL nop_stall op=%0d got=%b exp=0", codes[k], md_stall);
            end
            @(negedge clk);
            md_start = 1'b0; md_op = OP_NONE;
            #1;
            checks++;
            if (md_busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                failures++;
                $display("FAIL nop_state op=%0d busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                         codes[k], md_busy, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [64:0] r;
        logic [31:0] a, b;
        a = $urandom; b = $urandom;
        r = model_op(OP_MULT, a, b, m_hi, m_lo);
        @(negedge clk);
        md_start = 1'b1; md_op = OP_MULT; md_a = a; md_b = b;
        @(negedge clk);
        #1;
        for (int i = 1; i <= MC; i++) begin
            if (i == 2) begin
                md_start = 1'b1; md_op = OP_MTHI; md_a = 32'hDEAD; md_b = $urandom;
            end else if (i == 3) begin
                md_start = 1'b1; md_op = OP_DIV; md_a = $urandom; md_b = 32'd3;
            end else begin
                md_start = 1'b0; md_op = OP_NONE;
            end
            #1;
            checks++;
            if (md_busy !== 1'b1 || md_stall !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
                failures++;
                $display("FAIL busy_ignore cycle%0d busy=%b stall=%b hi=%h lo=%h exp busy=1 stall=1 hi=%h lo=%h",
                         i, md_busy, md_stall, hi, lo, m_hi, m_lo);
            end
            @(negedge clk);
            #1;
        end
        m_hi = r[63:32]; m_lo = r[31:0];
        checks++;
        if (md_busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL busy_ignore_final busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                     md_busy, hi, lo, m_hi, m_lo);
        end
        // A div accepted in BUSY would show busy again after the mult commits.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL busy_ignore_late busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                     md_busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid();
        mt_write(OP_MTHI, 32'hAAAA_5555, "mthi_prerst");
        mt_write(OP_MTLO, 32'h1234_5678, "mtlo_prerst");
        @(negedge clk);
        md_start = 1'b1; md_op = OP_DIV; md_a = 32'd1000; md_b = 32'd7;
        @(negedge clk);
        md_start = 1'b0; md_op = OP_NONE;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_pre busy=%b exp=1", md_busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_stall !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_async busy=%b stall=%b hi=%h lo=%h exp 0/0/0/0", md_busy, md_stall, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (DC + 2) @(negedge clk);
        #1;
        checks++;
        if (md_busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_abort busy=%b hi=%h lo=%h exp 0/0/0", md_busy, hi, lo);
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        mt_write(OP_MTHI, 32'd0, "mthi_madd");
        mt_write(OP_MTLO, 32'd1, "mtlo_madd");
        run_md(OP_MADD, 32'd2, 32'd3, "madd_2x3");
        checks++;
        if (hi !== 32'd0 || lo !== 32'd7) begin
            failures++;
            $display("FAIL madd_const hi=%h lo=%h exp hi=00000000 lo=00000007", hi, lo);
        end
        run_md(OP_MSUB, 32'd4, 32'd2, "msub_4x2");
        run_md(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu_max");
        run_md(OP_MSUBU, 32'h8000_0000, 32'd3, "msubu");
    endtask
`endif

    task automatic test_random();
        logic [3:0] ops[$];
        logic [3:0] op;
        logic [31:0] a, b;
        ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};
`ifdef MDU_MADD_EN
        ops.push_back(OP_MADD); ops.push_back(OP_MADDU);
        ops.push_back(OP_MSUB); ops.push_back(OP_MSUBU);
`endif
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(ops.size() - 1)];
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(3))
                0: b = 32'd0;
                1: begin a = $urandom_range(200); b = $urandom_range(9) - 4; end
                default: ;
            endcase
            if (op == OP_MTHI || op == OP_MTLO) mt_write(op, a, "rand_mt");
            else if (model_is_md(op)) run_md(op, a, b, "rand_md");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_nop();
        test_busy_ignore();
        test_reset_mid();
`ifdef MDU_MADD_EN
        test_madd();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
